pc_sequencer: RTL and testbench

//  Registered program-counter sequencer for the miniRISC fetch stage.

---
 rtl/pc_sequencer.sv | 136 +++++++++++++
 tb/tb_pc_sequencer.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Registered program-counter sequencer for the miniRISC fetch stage.
// Sequential/branch/jump/call/return selection with stall and a circular return-address stack.
module pc_sequencer #(
    parameter int unsigned        ADDR_W    = 32,
    parameter int unsigned        STEP      = 4,
    parameter logic [ADDR_W-1:0]  RESET_PC  = '0,
    parameter int unsigned        RAS_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        stall,
    input  logic                        JCout,
    input  logic                        UncondJump,
    input  logic                        Call,
    input  logic                        Ret,
    input  logic [ADDR_W-1:0]           JumpAddr,
    output logic [ADDR_W-1:0]           PC,
    output logic [ADDR_W-1:0]           PCnext,
    output logic [$clog2(RAS_DEPTH):0]  ras_count,
    output logic                        ras_overflow,
    output logic                        ras_underflow
);

    localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] r_pc;
    logic [PTR_W-1:0]  r_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              r_overflow;
    logic              r_underflow;
    logic [ADDR_W-1:0] r_ras [RAS_DEPTH];

    logic [ADDR_W-1:0] w_seq;
    logic [PTR_W-1:0]  w_top_idx;
    logic [ADDR_W-1:0] w_top;
    logic              w_empty;
    logic              w_full;

    logic [ADDR_W-1:0] w_pc_nxt;
    logic [PTR_W-1:0]  w_ptr_nxt;
    logic [CNT_W-1:0]  w_count_nxt;
    logic              w_overflow_nxt;
    logic              w_underflow_nxt;
    logic              w_wr_en;
    logic [PTR_W-1:0]  w_wr_idx;

    // r_ptr addresses the next free slot; the top of stack sits just below it.
    assign w_seq     = r_pc + ADDR_W'(STEP);
    assign w_top_idx = r_ptr - PTR_W'(1);
    assign w_top     = r_ras[w_top_idx];
    assign w_empty   = (r_count == CNT_W'(0));
    assign w_full    = (r_count == CNT_W'(RAS_DEPTH));

    // Next PC / RAS decision: Ret > Call > jump > sequential.
    always_comb begin
        w_pc_nxt        = w_seq;
        w_ptr_nxt       = r_ptr;
        w_count_nxt     = r_count;
        w_overflow_nxt  = 1'b0;
        w_underflow_nxt = 1'b0;
        w_wr_en         = 1'b0;
        w_wr_idx        = r_ptr;

        if (rst) begin
            w_pc_nxt    = RESET_PC;
            w_ptr_nxt   = '0;
            w_count_nxt = '0;
        end else if (stall) begin
            w_pc_nxt = r_pc;
        end else if (Ret && Call) begin
            if (w_empty) begin
                w_pc_nxt        = JumpAddr;
                w_wr_en         = 1'b1;
                w_ptr_nxt       = r_ptr + PTR_W'(1);
                w_count_nxt     = r_count + CNT_W'(1);
                w_underflow_nxt = 1'b1;
            end else begin
                // Swap: return to top and leave the new link in its place.
                w_pc_nxt = w_top;
                w_wr_en  = 1'b1;
                w_wr_idx = w_top_idx;
            end
        end else if (Ret) begin
            if (w_empty) begin
                w_underflow_nxt = 1'b1;
            end else begin
                w_pc_nxt    = w_top;
                w_ptr_nxt   = w_top_idx;
                w_count_nxt = r_count - CNT_W'(1);
            end
        end else if (Call) begin
            w_pc_nxt  = JumpAddr;
            w_wr_en   = 1'b1;
            w_ptr_nxt = r_ptr + PTR_W'(1);
            // A full stack has its oldest entry at r_ptr, so the push evicts it.
            if (w_full) begin
                w_overflow_nxt = 1'b1;
            end else begin
                w_count_nxt = r_count + CNT_W'(1);
            end
        end else if (JCout || UncondJump) begin
            w_pc_nxt = JumpAddr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc        <= RESET_PC;
            r_ptr       <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_pc        <= w_pc_nxt;
            r_ptr       <= w_ptr_nxt;
            r_count     <= w_count_nxt;
            r_overflow  <= w_overflow_nxt;
            r_underflow <= w_underflow_nxt;
        end
    end

    // Stack storage needs no reset; r_count qualifies the entries.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_ras[w_wr_idx] <= w_seq;
        end
    end

    assign PC            = r_pc;
    assign PCnext        = w_pc_nxt;
    assign ras_count     = r_count;
    assign ras_overflow  = r_overflow;
    assign ras_underflow = r_underflow;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: queue-based reference model plus directed scenarios.
module tb_pc_sequencer;

    localparam int unsigned ADDR_W    = 32;
    localparam int unsigned RAS_DEPTH = 4;

    logic              clk;
    logic              rst;
    logic              stall;
    logic              JCout;
    logic              UncondJump;
    logic              Call;
    logic              Ret;
    logic [31:0]       JumpAddr;
    logic [31:0]       PC;
    logic [31:0]       PCnext;
    logic [2:0]        ras_count;
    logic              ras_overflow;
    logic              ras_underflow;

    pc_sequencer #(
        .ADDR_W   (ADDR_W),
        .STEP     (4),
        .RESET_PC (32'h0),
        .RAS_DEPTH(RAS_DEPTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .JCout        (JCout),
        .UncondJump   (UncondJump),
        .Call         (Call),
        .Ret          (Ret),
        .JumpAddr     (JumpAddr),
        .PC           (PC),
        .PCnext       (PCnext),
        .ras_count    (ras_count),
        .ras_overflow (ras_overflow),
        .ras_underflow(ras_underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: link stack as a queue, newest at the back.
    logic [31:0] m_pc;
    logic [31:0] m_q[$];
    logic        m_ovf;
    logic        m_unf;
    bit          m_valid = 1'b0;

    function automatic logic [31:0] model_next_pc();
        if (rst)                         return 32'h0;
        if (stall)                       return m_pc;
        if (Ret && m_q.size() > 0)       return m_q[m_q.size()-1];
        if (Call)                        return JumpAddr;
        if (Ret)                         return m_pc + 32'd4;
        if (JCout || UncondJump)         return JumpAddr;
        return m_pc + 32'd4;
    endfunction

    always @(posedge clk) begin
        logic [31:0] pcn;
        if (rst) begin
            m_q.delete();
            m_pc    = 32'h0;
            m_ovf   = 1'b0;
            m_unf   = 1'b0;
            m_valid = 1'b1;
        end else if (m_valid) begin
            m_ovf = 1'b0;
            m_unf = 1'b0;
            if (!stall) begin
                pcn   = model_next_pc();
                m_unf = Ret && (m_q.size() == 0);
                if (Ret && Call && m_q.size() > 0) begin
                    m_q[m_q.size()-1] = m_pc + 32'd4;
                end else if (Ret && m_q.size() > 0) begin
                    void'(m_q.pop_back());
                end else if (Call) begin
                    m_q.push_back(m_pc + 32'd4);
                    if (m_q.size() > RAS_DEPTH) begin
                        void'(m_q.pop_front());
                        m_ovf = 1'b1;
                    end
                end
                m_pc = pcn;
            end
        end
    end

    // Every-cycle comparison, mid-cycle while inputs are stable.
    always @(negedge clk) begin
        if (m_valid) begin
            chk("pc",        PC,                    m_pc);
            chk("pcnext",    PCnext,                model_next_pc());
            chk("ras_count", 32'(ras_count),        32'(m_q.size()));
            chk("overflow",  32'(ras_overflow),     32'(m_ovf));
            chk("underflow", 32'(ras_underflow),    32'(m_unf));
        end
    end

    // Apply one cycle of controls, then return just after the consuming edge.
    task automatic drv(input logic r, input logic s, input logic jc, input logic uj,
                       input logic ca, input logic rt, input logic [31:0] a);
        rst        = r;
        stall      = s;
        JCout      = jc;
        UncondJump = uj;
        Call       = ca;
        Ret        = rt;
        JumpAddr   = a;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drv(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    initial begin
        // 1: reset then free run
        drv(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        drv(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        chk("lit_reset_pc", PC, 32'h0);
        chk("lit_reset_cnt", 32'(ras_count), 32'h0);
        idle();
        chk("lit_seq4", PC, 32'd4);
        idle();
        chk("lit_seq8", PC, 32'd8);

        // 2: conditional branch and unconditional jump
        drv(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd100);
        chk("lit_jc", PC, 32'd100);
        drv(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd40);
        chk("lit_uj", PC, 32'd40);

        // 3: call and return
        drv(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd200);
        chk("lit_call_pc", PC, 32'd200);
        chk("lit_call_cnt", 32'(ras_count), 32'd1);
        drv(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
        chk("lit_ret_pc", PC, 32'd44);
        chk("lit_ret_cnt", 32'(ras_count), 32'd0);

        // 4: five calls overflow a 4-deep stack, then drain it
        for (int i = 1; i <= 5; i++) begin
            drv(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'(i * 32'h100));
            if (i == 4) chk("lit_no_ovf4", 32'(ras_overflow), 32'd0);
        end
        chk("lit_ovf5", 32'(ras_overflow), 32'd1);
        chk("lit_cnt_full", 32'(ras_count), 32'd4);
        idle();
        chk("lit_ovf_pulse", 32'(ras_overflow), 32'd0);
        chk("lit_after_ovf_pc", PC, 32'h504);
        for (int i = 4; i >= 1; i--) begin
            drv(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
            chk("lit_lifo", PC, 32'(i * 32'h100 + 32'd4));
        end
        drv(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
        chk("lit_unf_pc", PC, 32'h108);
        chk("lit_unf", 32'(ras_underflow), 32'd1);
        idle();
        chk("lit_unf_pulse", 32'(ras_underflow), 32'd0);

        // 5: stall holds PC despite JCout, then release
        for (int i = 0; i < 3; i++) begin
            drv(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'd999);
            chk("lit_stall_pc", PC, 32'h10C);
        end
        drv(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'd999);
        chk("lit_stall_cnt", 32'(ras_count), 32'd0);
        drv(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd60);
        chk("lit_release", PC, 32'd60);

        // 6: wrap, swap, reset mid-sequence, empty-stack cases
        drv(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFC);
        chk("lit_top", PC, 32'hFFFF_FFFC);
        idle();
        chk("lit_wrap", PC, 32'h0);
        drv(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h10);
        drv(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h20);
        drv(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h30);
        chk("lit_cnt3", 32'(ras_count), 32'd3);
        drv(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h77);
        chk("lit_swap_pc", PC, 32'h24);
        chk("lit_swap_cnt", 32'(ras_count), 32'd3);
        drv(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
        chk("lit_swap_link", PC, 32'h34);
        drv(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h40);
        drv(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h55);
        chk("lit_rst_pc", PC, 32'h0);
        chk("lit_rst_cnt", 32'(ras_count), 32'd0);
        drv(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
        chk("lit_rst_unf", 32'(ras_underflow), 32'd1);
        chk("lit_rst_unf_pc", PC, 32'h4);
        drv(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h80);
        chk("lit_cr_empty_pc", PC, 32'h80);
        chk("lit_cr_empty_unf", 32'(ras_underflow), 32'd1);
        chk("lit_cr_empty_cnt", 32'(ras_count), 32'd1);
        drv(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h90);
        chk("lit_both_jump", PC, 32'h90);
        drv(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'hAA);
        chk("lit_ret_over_jc", PC, 32'h8);
        idle();
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
